// File: rtl/aes_pkg.sv
// Shared AES types, SubBytes FSM states and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

  localparam int unsigned NUM_BYTES = 16;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [8*NUM_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } sub_state_t;

  // Byte x of the table sits at bits [(255-x)*8 +: 8], i.e. entry 0x00 is the MSB byte.
  function automatic logic [2047:0] sbox_table();
    return {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
    };
  endfunction

  localparam logic [2047:0] SBOX_TABLE = sbox_table();

  function automatic logic [2047:0] inv_sbox_table();
    logic [2047:0] t;
    aes_byte_t     f;
    t = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      f = SBOX_TABLE[{~8'(i), 3'b000} +: 8];
      t[{~f, 3'b000} +: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] INV_SBOX_TABLE = inv_sbox_table();

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse AES S-box (FIPS-197).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] subst,
  output logic [7:0] value
);

  assign value = INV_SBOX_TABLE[{~subst, 3'b000} +: 8];

endmodule

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (FIPS-197).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  assign subst = SBOX_TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential SubBytes engine: LANES S-boxes per cycle over a 16-byte state, valid/ready in and out.
// Define AES_SUBBYTES_SELFCHECK_EN to add the inverse-S-box self-check and the sticky chk_err port.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_SUBBYTES_SELFCHECK_EN
  output logic         chk_err,
`endif
  output logic         busy
);

  if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_lanes_chk
    $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_state_t state, state_nxt;
  logic [3:0] cnt;
  aes_state_t work;
  logic       last_grp;

  logic [3:0] lane_idx [LANES];
  aes_byte_t  pre_byte [LANES];
  aes_byte_t  sub_byte [LANES];

  assign last_grp = (cnt == 4'(NUM_BYTES - LANES));

`ifdef AES_SUBBYTES_SELFCHECK_EN
  aes_byte_t        chk_byte [LANES];
  logic [LANES-1:0] lane_err;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = cnt + 4'(l);
    assign pre_byte[l] = work[{~lane_idx[l], 3'b000} +: 8];
    aes_sbox u_sbox (
      .value (pre_byte[l]),
      .subst (sub_byte[l])
    );
`ifdef AES_SUBBYTES_SELFCHECK_EN
    aes_inv_sbox u_inv_sbox (
      .subst (sub_byte[l]),
      .value (chk_byte[l])
    );
    assign lane_err[l] = (chk_byte[l] != pre_byte[l]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SUB;
      SUB:     if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst so nothing is offered as accepted during the reset cycle.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state == SUB) || (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            cnt  <= '0;
          end
        end
        SUB: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            work[{~lane_idx[l], 3'b000} +: 8] <= sub_byte[l];
          end
          cnt <= cnt + 4'(LANES);
        end
        default: ;
      endcase
    end
  end

`ifdef AES_SUBBYTES_SELFCHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                            chk_err <= 1'b0;
    else if (state == SUB && |lane_err) chk_err <= 1'b1;
  end
`endif

  assign out_data = work;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed self-checking bench for aes_sub_bytes_seq at LANES = 1, 4 and 16.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         iv   [3];
  logic         ordy [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         bz   [3];
  logic [127:0] od   [3];
`ifdef AES_SUBBYTES_SELFCHECK_EN
  logic         chk  [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [127:0] V_ZERO = 128'h0;
  localparam logic [127:0] E_ZERO = {16{8'h63}};
  localparam logic [127:0] V_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_SEQ  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] V_FF   = {16{8'hff}};
  localparam logic [127:0] E_FF   = {16{8'h16}};
  localparam logic [127:0] V_53   = {16{8'h53}};
  localparam logic [127:0] E_53   = {16{8'hed}};

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
`ifdef AES_SUBBYTES_SELFCHECK_EN
    .chk_err(chk[0]),
`endif
    .busy(bz[0])
  );

  aes_sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
`ifdef AES_SUBBYTES_SELFCHECK_EN
    .chk_err(chk[1]),
`endif
    .busy(bz[1])
  );

  aes_sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
`ifdef AES_SUBBYTES_SELFCHECK_EN
    .chk_err(chk[2]),
`endif
    .busy(bz[2])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts posedges starting with the accept edge until out_valid is seen; bounded.
  task automatic wait_out(input int k, input bit drop, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      if (drop) iv[k] = 1'b0;
      lat++;
    end while (ov[k] !== 1'b1 && lat < 60);
  endtask

  task automatic xfer(input int k, input logic [127:0] din, input logic [127:0] exp,
                      input int exp_lat, input string tag);
    int lat;
    in_data = din;
    iv[k]   = 1'b1;
    ordy[k] = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 128'(ir[k]), 128'd1);
    wait_out(k, 1'b1, lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, od[k], exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 128'(ov[k]), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    rst     = 1'b1;
    in_data = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b0;
    end

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 128'(ir[1]), 128'd0);
    check("rst_out_valid", 128'(ov[1]), 128'd0);
    check("rst_out_data", od[1], 128'd0);
    check("rst_busy", 128'(bz[1]), 128'd0);
`ifdef AES_SUBBYTES_SELFCHECK_EN
    check("rst_chk_err", 128'(chk[1]), 128'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(ir[1]), 128'd1);
    @(posedge clk); #1;

    // Main function at each lane count
    xfer(1, V_ZERO, E_ZERO, 5, "l4_zero");
    xfer(1, V_SEQ, E_SEQ, 5, "l4_seq");
    xfer(0, V_SEQ, E_SEQ, 17, "l1_seq");
    xfer(2, V_SEQ, E_SEQ, 2, "l16_seq");
    xfer(2, V_53, E_53, 2, "l16_53");

    // Output stall: result held, input side closed, in_valid ignored
    in_data = V_SEQ; iv[1] = 1'b1; ordy[1] = 1'b0;
    wait_out(1, 1'b1, lat);
    check("stall_latency", 128'(lat), 128'd5);
    for (int i = 0; i < 10; i++) begin
      iv[1]   = 1'b1;
      in_data = {16{8'(i + 1)}};
      @(negedge clk);
      check("stall_valid", 128'(ov[1]), 128'd1);
      check("stall_data", od[1], E_SEQ);
      check("stall_in_ready", 128'(ir[1]), 128'd0);
      @(posedge clk); #1;
    end
    iv[1] = 1'b0; in_data = V_SEQ; ordy[1] = 1'b1;
    @(posedge clk); #1;
    check("stall_release_valid", 128'(ov[1]), 128'd0);
    check("stall_release_busy", 128'(bz[1]), 128'd0);

    // Back-to-back with in_valid and out_ready held high
    in_data = V_ZERO; iv[1] = 1'b1; ordy[1] = 1'b1;
    wait_out(1, 1'b0, lat);
    check("b2b_lat1", 128'(lat), 128'd5);
    check("b2b_data1", od[1], E_ZERO);
    in_data = V_FF;
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_accept2", 128'(ir[1]), 128'd1);
    wait_out(1, 1'b1, lat);
    check("b2b_lat2", 128'(lat), 128'd5);
    check("b2b_data2", od[1], E_FF);
    @(posedge clk); #1;
    check("b2b_valid_drop", 128'(ov[1]), 128'd0);

    // Reset during SUB discards the state
    in_data = V_SEQ; iv[1] = 1'b1; ordy[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 128'(bz[1]), 128'd0);
    check("midrst_data", od[1], 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov[1] === 1'b1) seen = 1'b1;
    end
    check("midrst_no_output", 128'(seen), 128'd0);
    xfer(1, V_SEQ, E_SEQ, 5, "midrst_next");

`ifdef AES_SUBBYTES_SELFCHECK_EN
    for (int n = 0; n < 200; n++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      iv[1] = 1'b1; ordy[1] = 1'b1;
      wait_out(1, 1'b1, lat);
      @(posedge clk); #1;
    end
    check("selfchk_clean", 128'(chk[1]), 128'd0);
    force u_l4.sub_byte[0] = 8'h00;
    in_data = V_ZERO; iv[1] = 1'b1; ordy[1] = 1'b1;
    wait_out(1, 1'b1, lat);
    @(posedge clk); #1;
    release u_l4.sub_byte[0];
    check("selfchk_corrupt", 128'(chk[1]), 128'd1);
    xfer(1, V_SEQ, E_SEQ, 5, "selfchk_after");
    check("selfchk_sticky", 128'(chk[1]), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("selfchk_rst", 128'(chk[1]), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
